// File: rtl/whistle_pkg.sv
// Shared types and width helpers for the whistle event sequencer.
package whistle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        ACTIVE,
        REPORT,
        COOLDOWN
    } state_e;

    // Event fields are stored at a fixed container width; the module narrows them to DUR_W/BIN_W.
    localparam int unsigned EVT_W = 32;

    typedef struct packed {
        logic             is_long;
        logic [EVT_W-1:0] frames;
        logic [EVT_W-1:0] bin;
    } whistle_event_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/whistle_event_sequencer.sv
// Turns per-frame FFT peak results into debounced whistle events with
// duration, short/long class, onset bin, and a post-event cooldown.
module whistle_event_sequencer
    import whistle_pkg::*;
#(
    parameter int unsigned BIN_W           = 8,
    parameter int unsigned MAG_W           = 16,
    parameter int unsigned DUR_W           = 8,
    parameter int unsigned ATTACK_FRAMES   = 3,
    parameter int unsigned MISS_TOL        = 1,
    parameter int unsigned LONG_FRAMES     = 40,
    parameter int unsigned COOLDOWN_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_valid,
    input  logic [BIN_W-1:0] frame_bin,
    input  logic [MAG_W-1:0] frame_mag,
    input  logic             cfg_enable,
    input  logic [BIN_W-1:0] cfg_bin_lo,
    input  logic [BIN_W-1:0] cfg_bin_hi,
    input  logic [MAG_W-1:0] cfg_mag_thresh,
    output logic             whistle_active,
    output logic             event_valid,
    output logic             event_long,
    output logic [DUR_W-1:0] event_frames,
    output logic [BIN_W-1:0] event_bin,
    output logic             busy
);

    localparam int unsigned CW = cnt_w(COOLDOWN_CYCLES);
    localparam int unsigned HW = cnt_w(ATTACK_FRAMES);
    localparam int unsigned MW = cnt_w(MISS_TOL + 1);

    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [CW-1:0]    CD_LOAD =
        CW'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);

    state_e           state_q,    state_d;
    logic [BIN_W-1:0] bin_q,      bin_d;
    logic [HW-1:0]    hit_cnt_q,  hit_cnt_d;
    logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
    logic [DUR_W-1:0] dur_q,      dur_d;
    logic [CW-1:0]    timer_q,    timer_d;
    whistle_event_t   ev_q,       ev_d;
    logic             event_valid_q, event_valid_d;
    logic             active_q,   active_d;
    logic             busy_q,     busy_d;

    logic             hit;
    logic             miss;
    logic [HW-1:0]    hit_cnt_inc;
    logic [MW-1:0]    miss_cnt_inc;
    logic [DUR_W-1:0] dur_inc;

    assign hit = frame_valid && cfg_enable
              && (frame_bin >= cfg_bin_lo) && (frame_bin <= cfg_bin_hi)
              && (frame_mag >= cfg_mag_thresh);
    assign miss = frame_valid && !hit;

    assign hit_cnt_inc  = hit_cnt_q + HW'(1);
    assign miss_cnt_inc = miss_cnt_q + MW'(1);
    assign dur_inc      = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_W'(1);

    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        dur_d         = dur_q;
        timer_d       = timer_q;
        ev_d          = ev_q;
        event_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    bin_d      = frame_bin;
                    hit_cnt_d  = HW'(1);
                    dur_d      = DUR_W'(1);
                    miss_cnt_d = '0;
                    state_d    = (ATTACK_FRAMES == 1) ? ACTIVE : ATTACK;
                end
            end
            ATTACK: begin
                if (!cfg_enable || miss) begin
                    state_d = IDLE;
                end else if (hit) begin
                    hit_cnt_d = hit_cnt_inc;
                    dur_d     = dur_inc;
                    if (hit_cnt_inc == HW'(ATTACK_FRAMES)) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                // dur_q already excludes the terminating frame, so it is the final count here.
                if (!cfg_enable || (miss && (miss_cnt_inc > MW'(MISS_TOL)))) begin
                    state_d       = REPORT;
                    event_valid_d = 1'b1;
                    ev_d.is_long  = (EVT_W'(dur_q) >= EVT_W'(LONG_FRAMES));
                    ev_d.frames   = EVT_W'(dur_q);
                    ev_d.bin      = EVT_W'(bin_q);
                end else if (hit) begin
                    dur_d      = dur_inc;
                    miss_cnt_d = '0;
                end else if (miss) begin
                    miss_cnt_d = miss_cnt_inc;
                end
            end
            REPORT: begin
                if (COOLDOWN_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = COOLDOWN;
                    timer_d = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_d = (state_d == ACTIVE);
    assign busy_d   = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            dur_q         <= '0;
            timer_q       <= '0;
            ev_q          <= '0;
            event_valid_q <= 1'b0;
            active_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            dur_q         <= dur_d;
            timer_q       <= timer_d;
            ev_q          <= ev_d;
            event_valid_q <= event_valid_d;
            active_q      <= active_d;
            busy_q        <= busy_d;
        end
    end

    assign whistle_active = active_q;
    assign event_valid    = event_valid_q;
    assign event_long     = ev_q.is_long;
    assign event_frames   = ev_q.frames[DUR_W-1:0];
    assign event_bin      = ev_q.bin[BIN_W-1:0];
    assign busy           = busy_q;

endmodule
